sgf_mult_sequencer: RTL and testbench
=====================================

// Module: sgf_mult_sequencer
// PURPOSE
//  Control FSM for the significand-multiply phase of the FP multiplier.
//  Drives the operand-register load (load_a) and product-register load (load_b)
//  of the significand multiply stage, and allots MULT_CYC clock cycles to the
//  combinational multiplier between them (the multiplier is a multicycle path).
//  Uses a start/done/ack handshake toward the top-level FP multiplier FSM.
// PARAMETERS
//  MULT_CYC  3  cycles from the operand-register load to the product-register
//               load; legal range 1..15
//  W_CNT     4  width of the wait counter; 2**W_CNT must exceed MULT_CYC
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  start_i    in   1        request one multiply; sampled only in IDLE or DONE
//  ack_i      in   1        consumer has taken the product; sampled only in DONE
//  abort_i    in   1        cancel the current operation; sampled in any non-IDLE state
//  clr_err_i  in   1        clears err_o
//  load_a     out  1        1-cycle pulse that loads the X/Y significand registers
//  load_b     out  1        1-cycle pulse that loads the product register P_Sgf
//  busy_o     out  1        high in every state except IDLE
//  done_o     out  1        P_Sgf is valid; held until ack_i or abort_i
//  err_o      out  1        sticky flag: start_i was seen while busy and not in DONE
//  state_o    out  3        current state encoding, for debug
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE; counter=0; all outputs 0.
//   Takes effect mid-operation with no pending load_b.
//  States and encoding: IDLE=0, LOAD_OP=1, WAIT_MUL=2, LOAD_P=3, DONE=4.
//   Codes 5..7 are illegal and return to IDLE on the next edge.
//  Outputs are Moore-decoded from the registered state:
//   load_a=(LOAD_OP), load_b=(LOAD_P), done_o=(DONE), busy_o=(state!=IDLE).
//  Transitions (abort_i has the highest priority in every non-IDLE state):
//   IDLE:     start_i -> LOAD_OP; otherwise stay in IDLE.
//   LOAD_OP:  abort_i -> IDLE; otherwise -> WAIT_MUL, counter loaded with MULT_CYC-1.
//   WAIT_MUL: abort_i -> IDLE; counter==0 -> LOAD_P; otherwise decrement the counter.
//   LOAD_P:   abort_i -> IDLE; otherwise -> DONE.
//   DONE:     abort_i -> IDLE; ack_i&start_i -> LOAD_OP (back-to-back);
//             ack_i -> IDLE; otherwise stay in DONE.
//  Latency, with start_i high in cycle 0 in IDLE:
//   load_a in cycle 1; WAIT_MUL in cycles 2..MULT_CYC+1;
//   load_b in cycle MULT_CYC+2; done_o from cycle MULT_CYC+3.
//   The default (3) gives load_b in cycle 5 and done_o in cycle 6.
//  Throughput: one operation per MULT_CYC+3 cycles when ack_i is returned in
//   the first DONE cycle together with the next start_i.
//  start_i in LOAD_OP, WAIT_MUL or LOAD_P: ignored and sets err_o on the next edge.
//   start_i in DONE without ack_i: ignored, no error.
//  err_o is cleared by clr_err_i. If a clear and a new error occur in the same
//   cycle, the error wins (err_o stays 1).
//  Exactly one load_a pulse and at most one load_b pulse per accepted start.
//   load_b never occurs after an abort.
//  ack_i outside DONE and abort_i in IDLE have no effect.
// TESTING
//  T1 Basic: rst low then high, start_i=1 for 1 cycle in cycle 0 -> load_a=1 in
//     cycle 1 only, load_b=1 in cycle 5 only, done_o=1 from cycle 6 until ack_i,
//     IDLE on the cycle after ack_i.
//  T2 Back-to-back: ack_i=1 and start_i=1 in the first DONE cycle (cycle 6) ->
//     load_a in cycle 7, load_b in cycle 11, done_o in cycle 12; busy_o stays 1
//     throughout.
//  T3 Abort: abort_i=1 in cycle 3 (WAIT_MUL) -> IDLE in cycle 4; no load_b and
//     no done_o; busy_o=0 from cycle 4.
//  T4 Overrun: start_i=1 in cycle 2 -> err_o=1 from cycle 3, operation still
//     completes as in T1; clr_err_i=1 for 1 cycle -> err_o=0.
//  T5 Reset mid-op: rst=0 asynchronously in cycle 4 -> all outputs 0
//     immediately, state_o=0; after release, the next start behaves as T1.
//  T6 Parameter sweep: MULT_CYC=1 -> load_b in cycle 3, done_o in cycle 4;
//     MULT_CYC=15 -> load_b in cycle 17, done_o in cycle 18.

Source files
------------

// File: rtl/sgf_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sgf_mult_sequencer
// Purpose  : Control FSM for the significand-multiply phase of the FP
//            multiplier. Pulses load_a to capture the X/Y significand
//            operands, allots MULT_CYC cycles to the multicycle combinational
//            multiplier, then pulses load_b to capture the product P_Sgf.
//            Talks to the top-level FP multiplier FSM with start/done/ack.
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous reset, active-low
//            start_i   - request one multiply (honoured in IDLE or DONE)
//            ack_i     - product consumed (honoured in DONE)
//            abort_i   - cancel the current operation (any non-IDLE state)
//            clr_err_i - clears the sticky overrun flag
//            load_a    - 1-cycle pulse, load operand registers
//            load_b    - 1-cycle pulse, load product register
//            busy_o    - high in every state except IDLE
//            done_o    - product valid, held until ack_i or abort_i
//            err_o     - sticky: start_i seen while busy and not in DONE
//            state_o   - current state encoding, for debug
// Revision : 1.0 - initial release
// ============================================================================
module sgf_mult_sequencer #(
   parameter int MULT_CYC = 3,
   parameter int W_CNT    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       ack_i,
   input  logic       abort_i,
   input  logic       clr_err_i,
   output logic       load_a,
   output logic       load_b,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_OP  = 3'd1;
   localparam logic [2:0] S_WAIT_MUL = 3'd2;
   localparam logic [2:0] S_LOAD_P   = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   // The counter is loaded in LOAD_OP and counts down to zero in WAIT_MUL,
   // so WAIT_MUL lasts exactly MULT_CYC cycles.
   localparam logic [W_CNT-1:0] C_CNT_INIT = W_CNT'(MULT_CYC - 1);

   logic [2:0]       state_q, state_d;
   logic [W_CNT-1:0] cnt_q,   cnt_d;
   logic             err_q,   err_d;
   logic             err_set;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD_OP;
         end
         S_LOAD_OP: begin
            err_set = start_i;
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_MUL;
               cnt_d   = C_CNT_INIT;
            end
         end
         S_WAIT_MUL: begin
            err_set = start_i;
            if (abort_i)               state_d = S_IDLE;
            else if (cnt_q == '0)      state_d = S_LOAD_P;
            else                       cnt_d   = cnt_q - 1'b1;
         end
         S_LOAD_P: begin
            err_set = start_i;
            if (abort_i) state_d = S_IDLE;
            else         state_d = S_DONE;
         end
         S_DONE: begin
            // start_i without ack_i is simply ignored here (no overrun).
            if (abort_i)                state_d = S_IDLE;
            else if (ack_i && start_i)  state_d = S_LOAD_OP;
            else if (ack_i)             state_d = S_IDLE;
         end
         default: begin
            // Illegal codes 5..7 recover to IDLE.
            state_d = S_IDLE;
         end
      endcase

      // A new error outranks a simultaneous clear.
      err_d = err_set | (err_q & ~clr_err_i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Moore outputs decoded from the registered state, so an asynchronous
   // reset clears them immediately.
   assign load_a  = (state_q == S_LOAD_OP);
   assign load_b  = (state_q == S_LOAD_P);
   assign done_o  = (state_q == S_DONE);
   assign busy_o  = (state_q != S_IDLE);
   assign err_o   = err_q;
   assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sgf_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgf_mult_sequencer
// Purpose  : Self-checking bench for sgf_mult_sequencer. Three instances
//            (MULT_CYC = 3, 1, 15) share one set of inputs; a timeline model
//            (cycles elapsed since an accepted start) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgf_mult_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start_i, ack_i, abort_i, clr_err_i;
   logic [2:0] la, lb, bz, dn, er;
   logic [2:0] st [3];

   int  mc  [3] = '{3, 1, 15};
   int  tm  [3];   // cycles since accepted start (1 = load_a cycle), saturates in DONE
   bit  act [3];   // an operation is in progress
   bit  em  [3];   // expected sticky error
   int  total = 0;
   int  bad   = 0;

   sgf_mult_sequencer #(.MULT_CYC(3), .W_CNT(4)) u_d0 (
      .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
      .clr_err_i(clr_err_i), .load_a(la[0]), .load_b(lb[0]), .busy_o(bz[0]),
      .done_o(dn[0]), .err_o(er[0]), .state_o(st[0]));

   sgf_mult_sequencer #(.MULT_CYC(1), .W_CNT(2)) u_d1 (
      .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
      .clr_err_i(clr_err_i), .load_a(la[1]), .load_b(lb[1]), .busy_o(bz[1]),
      .done_o(dn[1]), .err_o(er[1]), .state_o(st[1]));

   sgf_mult_sequencer #(.MULT_CYC(15), .W_CNT(4)) u_d2 (
      .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
      .clr_err_i(clr_err_i), .load_a(la[2]), .load_b(lb[2]), .busy_o(bz[2]),
      .done_o(dn[2]), .err_o(er[2]), .state_o(st[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_state(int k);
      if (!act[k])              return 3'd0;
      if (tm[k] == 1)           return 3'd1;
      if (tm[k] <= mc[k] + 1)   return 3'd2;
      if (tm[k] == mc[k] + 2)   return 3'd3;
      return 3'd4;
   endfunction

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d.load_a", k),  la[k], act[k] && tm[k] == 1);
         chk($sformatf("d%0d.load_b", k),  lb[k], act[k] && tm[k] == mc[k] + 2);
         chk($sformatf("d%0d.done", k),    dn[k], act[k] && tm[k] == mc[k] + 3);
         chk($sformatf("d%0d.busy", k),    bz[k], act[k]);
         chk($sformatf("d%0d.err", k),     er[k], em[k]);
         chk($sformatf("d%0d.state", k),   st[k], exp_state(k));
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         act[k] = 1'b0; tm[k] = 0; em[k] = 1'b0;
      end
   endtask

   // Advance one clock: predict from the current inputs, take the edge,
   // then compare every output 1 time unit later.
   task automatic cyc(input int n);
      int  nt [3];
      bit  na [3];
      bit  ne [3];
      repeat (n) begin
         for (int k = 0; k < 3; k++) begin
            bit done_now;
            bit set_err;
            done_now = act[k] && (tm[k] == mc[k] + 3);
            set_err  = act[k] && !done_now && start_i;
            na[k] = act[k]; nt[k] = tm[k];
            if (!act[k]) begin
               if (start_i) begin na[k] = 1'b1; nt[k] = 1; end
            end else if (abort_i) begin
               na[k] = 1'b0;
            end else if (done_now) begin
               if (ack_i && start_i) nt[k] = 1;
               else if (ack_i)       na[k] = 1'b0;
            end else begin
               nt[k] = tm[k] + 1;
            end
            ne[k] = set_err ? 1'b1 : (clr_err_i ? 1'b0 : em[k]);
         end
         @(posedge clk);
         #1;
         if (!rst) model_reset();
         else begin
            for (int k = 0; k < 3; k++) begin
               act[k] = na[k]; tm[k] = nt[k]; em[k] = ne[k];
            end
         end
         check_all();
      end
   endtask

   task automatic idle_inputs();
      start_i = 1'b0; ack_i = 1'b0; abort_i = 1'b0; clr_err_i = 1'b0;
   endtask

   task automatic cleanup();
      idle_inputs();
      abort_i = 1'b1; clr_err_i = 1'b1;
      cyc(1);
      idle_inputs();
      cyc(1);
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      #1;
      model_reset();
      check_all();
      cyc(2);
      rst = 1'b1;
      cyc(1);

      // T1 + T6: single start, all three instances run their own latency.
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         if (c > 1) cyc(1);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("T1 c%0d d%0d load_a", c, k), la[k], c == 1);
            chk($sformatf("T1 c%0d d%0d load_b", c, k), lb[k], c == mc[k] + 2);
            chk($sformatf("T1 c%0d d%0d done", c, k),   dn[k], c >= mc[k] + 3);
         end
      end
      ack_i = 1'b1;
      cyc(1);
      ack_i = 1'b0;
      chk("T1 idle after ack", bz[0], 1'b0);
      cleanup();

      // T2: back-to-back with ack+start in the first DONE cycle.
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      cyc(5);
      chk("T2 first done c6", dn[0], 1'b1);
      start_i = 1'b1; ack_i = 1'b1;
      for (int c = 7; c <= 12; c++) begin
         cyc(1);
         idle_inputs();
         chk($sformatf("T2 c%0d load_a", c), la[0], c == 7);
         chk($sformatf("T2 c%0d load_b", c), lb[0], c == 11);
         chk($sformatf("T2 c%0d done", c),   dn[0], c == 12);
         chk($sformatf("T2 c%0d busy", c),   bz[0], 1'b1);
      end
      cleanup();

      // T3: abort in WAIT_MUL.
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      cyc(2);
      abort_i = 1'b1;
      cyc(1);
      abort_i = 1'b0;
      for (int c = 4; c <= 8; c++) begin
         chk($sformatf("T3 c%0d busy", c),   bz[0], 1'b0);
         chk($sformatf("T3 c%0d load_b", c), lb[0], 1'b0);
         chk($sformatf("T3 c%0d done", c),   dn[0], 1'b0);
         cyc(1);
      end
      cleanup();

      // T4: overrun start in WAIT_MUL sets err; operation still completes.
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      cyc(1);
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      chk("T4 err c3", er[0], 1'b1);
      cyc(2);
      chk("T4 load_b c5", lb[0], 1'b1);
      cyc(1);
      chk("T4 done c6", dn[0], 1'b1);
      chk("T4 err held", er[0], 1'b1);
      clr_err_i = 1'b1;
      cyc(1);
      clr_err_i = 1'b0;
      chk("T4 err cleared", er[0], 1'b0);
      cleanup();

      // T5: asynchronous reset mid-operation.
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      cyc(3);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("T5 async state", st[0], 3'd0);
      chk("T5 async busy",  bz[0], 1'b0);
      check_all();
      cyc(1);
      rst = 1'b1;
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      chk("T5 reuse load_a", la[0], 1'b1);
      cyc(4);
      chk("T5 reuse load_b", lb[0], 1'b1);
      cyc(1);
      chk("T5 reuse done", dn[0], 1'b1);
      cleanup();

      // Randomized traffic against the timeline model.
      for (int i = 0; i < 800; i++) begin
         start_i   = ($urandom_range(0, 99) < 35);
         ack_i     = ($urandom_range(0, 99) < 40);
         abort_i   = ($urandom_range(0, 99) < 4);
         clr_err_i = ($urandom_range(0, 99) < 10);
         rst       = !($urandom_range(0, 199) == 0);
         cyc(1);
         rst = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
